// File: rtl/m_inst_seq_ctrl.sv
// m_inst_seq_ctrl: controller for the micro-instruction memory and its PC.
// Assembles micro-instructions from a byte-serial load bus (LS byte first),
// writes them into the memory, then sequences fetch (increment, branch,
// halt). It is the only driver of the memory's mode and address.
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   load_start/last      begin loading words 0..load_last
//   load_valid/data      serial load byte stream; load_ready accepts
//   run_start/start_pc   begin fetching at start_pc
//   branch_en/target     next PC = branch_target while running
//   halt                 stop fetching (PC held)
//   abort                return to IDLE from any state, PC preserved
//   mode, m_pc           memory mode and address
//   m_inst_load          assembled word presented during the write cycle
//   busy                 controller is not idle
//   load_done            one-cycle pulse after the last word is written
module m_inst_seq_ctrl #(
  parameter int unsigned MINST_WIDTH       = 44,
  parameter int unsigned PC_WIDTH          = 10,
  parameter int unsigned IN_WIDTH          = 8,
  parameter int unsigned M_INST_MODES      = 2,
  parameter int unsigned M_INST_IDLE_MODE  = 0,
  parameter int unsigned M_INST_LOAD_MODE  = 1,
  parameter int unsigned M_INST_FETCH_MODE = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    load_start,
  input  logic [PC_WIDTH-1:0]     load_last,
  input  logic                    load_valid,
  input  logic [IN_WIDTH-1:0]     load_data,
  output logic                    load_ready,
  input  logic                    run_start,
  input  logic [PC_WIDTH-1:0]     start_pc,
  input  logic                    branch_en,
  input  logic [PC_WIDTH-1:0]     branch_target,
  input  logic                    halt,
  input  logic                    abort,
  output logic [M_INST_MODES-1:0] mode,
  output logic [PC_WIDTH-1:0]     m_pc,
  output logic [MINST_WIDTH-1:0]  m_inst_load,
  output logic                    busy,
  output logic                    load_done
);

  localparam int unsigned BYTES     = (MINST_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
  localparam int unsigned ASM_WIDTH = BYTES * IN_WIDTH;
  localparam int unsigned IDX_WIDTH = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [M_INST_MODES-1:0] MODE_IDLE  = M_INST_MODES'(M_INST_IDLE_MODE);
  localparam logic [M_INST_MODES-1:0] MODE_LOAD  = M_INST_MODES'(M_INST_LOAD_MODE);
  localparam logic [M_INST_MODES-1:0] MODE_FETCH = M_INST_MODES'(M_INST_FETCH_MODE);
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_SHIFT,
    S_LOAD_WRITE,
    S_RUN,
    S_HALTED
  } state_t;

  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [PC_WIDTH-1:0]     load_addr_q, load_addr_d;
  logic [PC_WIDTH-1:0]     load_last_q, load_last_d;
  logic [IDX_WIDTH-1:0]    byte_idx_q, byte_idx_d;
  logic [ASM_WIDTH-1:0]    asm_q, asm_d;

  logic [M_INST_MODES-1:0] mode_q, mode_d;
  logic [PC_WIDTH-1:0]     m_pc_q, m_pc_d;
  logic [MINST_WIDTH-1:0]  m_inst_load_q, m_inst_load_d;
  logic                    load_ready_q, load_ready_d;
  logic                    busy_q, busy_d;
  logic                    load_done_q, load_done_d;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_addr_d   = load_addr_q;
    load_last_d   = load_last_q;
    byte_idx_d    = byte_idx_q;
    asm_d         = asm_q;
    load_done_d   = 1'b0;
    mode_d        = MODE_IDLE;
    m_pc_d        = pc_q;
    m_inst_load_d = '0;
    load_ready_d  = 1'b0;
    busy_d        = 1'b0;

    if (abort) begin
      // Partial word is dropped; pc is kept so a later run can resume
      state_d    = S_IDLE;
      byte_idx_d = '0;
      asm_d      = '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (load_start) begin
            state_d     = S_LOAD_SHIFT;
            load_addr_d = '0;
            load_last_d = load_last;
            byte_idx_d  = '0;
            asm_d       = '0;
          end else if (run_start) begin
            state_d = S_RUN;
            pc_d    = start_pc;
          end
        end

        S_LOAD_SHIFT: begin
          if (load_valid) begin
            for (int unsigned k = 0; k < BYTES; k++) begin
              if (byte_idx_q == IDX_WIDTH'(k)) begin
                asm_d[k*IN_WIDTH +: IN_WIDTH] = load_data;
              end
            end
            if (byte_idx_q == LAST_IDX) begin
              byte_idx_d = '0;
              state_d    = S_LOAD_WRITE;
            end else begin
              byte_idx_d = byte_idx_q + IDX_WIDTH'(1);
            end
          end
        end

        S_LOAD_WRITE: begin
          if (load_addr_q == load_last_q) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end else begin
            load_addr_d = load_addr_q + PC_WIDTH'(1);
            state_d     = S_LOAD_SHIFT;
          end
        end

        S_RUN: begin
          if (halt) begin
            state_d = S_HALTED;
          end else if (branch_en) begin
            pc_d = branch_target;
          end else begin
            pc_d = pc_q + PC_WIDTH'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Outputs are registered, so they are derived from the state being entered
    busy_d       = (state_d != S_IDLE);
    load_ready_d = (state_d == S_LOAD_SHIFT);
    case (state_d)
      S_LOAD_WRITE: begin
        mode_d        = MODE_LOAD;
        m_pc_d        = load_addr_d;
        m_inst_load_d = asm_d[MINST_WIDTH-1:0];
      end
      S_LOAD_SHIFT: begin
        m_pc_d = load_addr_d;
      end
      S_RUN: begin
        mode_d = MODE_FETCH;
        m_pc_d = pc_d;
      end
      default: begin
        m_pc_d = pc_d;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      load_addr_q   <= '0;
      load_last_q   <= '0;
      byte_idx_q    <= '0;
      asm_q         <= '0;
      mode_q        <= MODE_IDLE;
      m_pc_q        <= '0;
      m_inst_load_q <= '0;
      load_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      load_addr_q   <= load_addr_d;
      load_last_q   <= load_last_d;
      byte_idx_q    <= byte_idx_d;
      asm_q         <= asm_d;
      mode_q        <= mode_d;
      m_pc_q        <= m_pc_d;
      m_inst_load_q <= m_inst_load_d;
      load_ready_q  <= load_ready_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
    end
  end

  assign mode        = mode_q;
  assign m_pc        = m_pc_q;
  assign m_inst_load = m_inst_load_q;
  assign load_ready  = load_ready_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_m_inst_seq_ctrl.sv
// tb_m_inst_seq_ctrl: self-checking bench for m_inst_seq_ctrl.
// Per-cycle output expectations go through a queue; memory writes are
// checked by a monitor against a queue of expected {address, word} pairs.
module tb_m_inst_seq_ctrl;
  localparam int unsigned MW = 44;
  localparam int unsigned PW = 10;
  localparam int unsigned IW = 8;
  localparam int unsigned MB = 2;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [PW-1:0] load_last = '0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_data = '0;
  logic          load_ready;
  logic          run_start = 1'b0;
  logic [PW-1:0] start_pc = '0;
  logic          branch_en = 1'b0;
  logic [PW-1:0] branch_target = '0;
  logic          halt = 1'b0;
  logic          abort = 1'b0;
  logic [MB-1:0] mode;
  logic [PW-1:0] m_pc;
  logic [MW-1:0] m_inst_load;
  logic          busy;
  logic          load_done;

  m_inst_seq_ctrl #(
    .MINST_WIDTH(MW), .PC_WIDTH(PW), .IN_WIDTH(IW), .M_INST_MODES(MB),
    .M_INST_IDLE_MODE(0), .M_INST_LOAD_MODE(1), .M_INST_FETCH_MODE(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .load_start(load_start), .load_last(load_last),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .run_start(run_start), .start_pc(start_pc),
    .branch_en(branch_en), .branch_target(branch_target),
    .halt(halt), .abort(abort),
    .mode(mode), .m_pc(m_pc), .m_inst_load(m_inst_load),
    .busy(busy), .load_done(load_done)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic          ls;
    logic [PW-1:0] ll;
    logic          lv;
    logic [IW-1:0] ld;
    logic          rs;
    logic [PW-1:0] sp;
    logic          br;
    logic [PW-1:0] bt;
    logic          h;
    logic          ab;
  } in_t;

  typedef struct {
    logic [MB-1:0] mode;
    int            pc;    // -1: address not checked this cycle
    logic          ready;
    logic          busy;
    logic          done;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [MW-1:0] data;
  } wr_t;

  int    checks = 0;
  int    errors = 0;
  string tag = "init";
  exp_t  exp_q[$];
  wr_t   wr_q[$];
  vec_t  tbl[$];
  wr_t   mon_w;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s: got 0x%0h, expected 0x%0h (t=%0t)", tag, name, act, req, $time);
    end
  endtask

  function automatic in_t i_nop();
    in_t t = '0;
    return t;
  endfunction
  function automatic in_t i_ls(input logic [PW-1:0] last);
    in_t t = '0;
    t.ls = 1'b1; t.ll = last;
    return t;
  endfunction
  function automatic in_t i_byte(input logic [IW-1:0] d);
    in_t t = '0;
    t.lv = 1'b1; t.ld = d;
    return t;
  endfunction
  function automatic in_t i_stall();
    in_t t = '0;
    t.ld = 8'hFF;
    return t;
  endfunction
  function automatic in_t i_rs(input logic [PW-1:0] sp);
    in_t t = '0;
    t.rs = 1'b1; t.sp = sp;
    return t;
  endfunction
  function automatic in_t i_br(input logic [PW-1:0] bt);
    in_t t = '0;
    t.br = 1'b1; t.bt = bt;
    return t;
  endfunction
  function automatic in_t i_halt();
    in_t t = '0;
    t.h = 1'b1;
    return t;
  endfunction
  function automatic in_t i_abort();
    in_t t = '0;
    t.ab = 1'b1;
    return t;
  endfunction

  function automatic exp_t e(input logic [MB-1:0] m, input int pc,
                             input logic r, input logic b, input logic d);
    exp_t x;
    x.mode = m; x.pc = pc; x.ready = r; x.busy = b; x.done = d;
    return x;
  endfunction
  function automatic exp_t e_shift();
    return e(2'd0, -1, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic exp_t e_idle();
    return e(2'd0, -1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic exp_t e_write(input int addr);
    return e(2'd1, addr, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic exp_t e_run(input int pc);
    return e(2'd2, pc, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic exp_t e_halted(input int pc);
    return e(2'd0, pc, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic vec_t mkv(input in_t i, input exp_t x);
    vec_t v;
    v.i = i; v.e = x;
    return v;
  endfunction

  function automatic wr_t mkw(input logic [PW-1:0] a, input logic [MW-1:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    return w;
  endfunction

  task automatic drive(input in_t i);
    load_start    = i.ls;
    load_last     = i.ll;
    load_valid    = i.lv;
    load_data     = i.ld;
    run_start     = i.rs;
    start_pc      = i.sp;
    branch_en     = i.br;
    branch_target = i.bt;
    halt          = i.h;
    abort         = i.ab;
  endtask

  // One cycle: drive, queue the expectation, sample after the edge, compare
  task automatic apply(input in_t i, input exp_t x);
    exp_t got;
    drive(i);
    exp_q.push_back(x);
    @(posedge sys_clk);
    #1;
    got = exp_q.pop_front();
    chk("mode", 64'(mode), 64'(got.mode));
    if (got.pc >= 0) chk("m_pc", 64'(m_pc), 64'(got.pc));
    chk("load_ready", 64'(load_ready), 64'(got.ready));
    chk("busy", 64'(busy), 64'(got.busy));
    chk("load_done", 64'(load_done), 64'(got.done));
  endtask

  task automatic chk_reset();
    chk("rst_mode", 64'(mode), 64'd0);
    chk("rst_m_pc", 64'(m_pc), 64'd0);
    chk("rst_m_inst_load", 64'(m_inst_load), 64'd0);
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
  endtask

  // Memory-side monitor: legal modes only, and every write must be expected
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      chk("mode_legal", 64'(mode == 2'd3), 64'd0);
      if (mode == 2'd1) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s/spurious_write: got write addr=0x%0h data=0x%0h, expected no write",
                   tag, m_pc, m_inst_load);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_addr", 64'(m_pc), 64'(mon_w.addr));
          chk("wr_data", 64'(m_inst_load), 64'(mon_w.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    in_t t;

    // Reset values
    tag = "reset";
    #1;
    chk_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Two-word load, load_valid held high throughout
    tag = "load2";
    wr_q.push_back(mkw(10'd0, 44'h605_0403_0201));
    wr_q.push_back(mkw(10'd1, 44'h615_1413_1211));
    tbl.push_back(mkv(i_ls(10'd1), e_shift()));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mkv(i_byte(8'(k)), (k < 6) ? e_shift() : e_write(0)));
    tbl.push_back(mkv(i_byte(8'hAA), e_shift()));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(mkv(i_byte(8'h10 + 8'(k)), (k < 6) ? e_shift() : e_write(1)));
    tbl.push_back(mkv(i_byte(8'h55), e(2'd0, -1, 1'b0, 1'b0, 1'b1)));
    tbl.push_back(mkv(i_nop(), e_idle()));
    tbl.push_back(mkv(i_byte(8'h99), e_idle()));
    foreach (tbl[k]) apply(tbl[k].i, tbl[k].e);

    // Run with PC wrap, ignored starts, halt
    tag = "run_wrap";
    apply(i_rs(10'h3FE), e_run('h3FE));
    apply(i_nop(), e_run('h3FF));
    apply(i_ls(10'd0), e_run('h000));
    apply(i_rs(10'h100), e_run('h001));
    apply(i_halt(), e_halted('h001));
    apply(i_nop(), e_halted('h001));

    // Halt beats branch, then branch from pc=5
    tag = "branch_halt";
    apply(i_rs(10'd5), e_run(5));
    t = i_br(10'h20); t.h = 1'b1;
    apply(t, e_halted(5));
    apply(i_nop(), e_halted(5));
    apply(i_rs(10'd5), e_run(5));
    apply(i_br(10'h20), e_run('h20));
    apply(i_nop(), e_run('h21));
    apply(i_abort(), e_idle());

    // From HALTED, load_start wins over run_start
    tag = "halted_both";
    apply(i_rs(10'h30), e_run('h30));
    apply(i_halt(), e_halted('h30));
    t = i_ls(10'd0); t.rs = 1'b1; t.sp = 10'h40;
    apply(t, e_shift());
    apply(i_abort(), e_idle());

    // Abort after 4 bytes, then a fresh word must start at byte 0
    tag = "abort_load";
    apply(i_ls(10'd0), e_shift());
    apply(i_byte(8'hAA), e_shift());
    apply(i_byte(8'hBB), e_shift());
    apply(i_byte(8'hCC), e_shift());
    apply(i_byte(8'hDD), e_shift());
    t = i_byte(8'hEE); t.ab = 1'b1;
    apply(t, e_idle());
    apply(i_ls(10'd0), e_shift());
    apply(i_byte(8'h21), e_shift());
    apply(i_byte(8'h32), e_shift());
    apply(i_byte(8'h43), e_shift());
    apply(i_byte(8'h54), e_shift());
    apply(i_byte(8'h65), e_shift());
    wr_q.push_back(mkw(10'd0, 44'h665_5443_3221));
    apply(i_byte(8'hF6), e_write(0));
    apply(i_nop(), e(2'd0, -1, 1'b0, 1'b0, 1'b1));
    apply(i_nop(), e_idle());

    // Stalled load: only load_valid cycles consume bytes
    tag = "stall";
    apply(i_ls(10'd0), e_shift());
    apply(i_byte(8'h0F), e_shift());
    apply(i_stall(), e_shift());
    apply(i_stall(), e_shift());
    apply(i_byte(8'h1E), e_shift());
    apply(i_stall(), e_shift());
    apply(i_byte(8'h2D), e_shift());
    apply(i_byte(8'h3C), e_shift());
    apply(i_byte(8'h4B), e_shift());
    wr_q.push_back(mkw(10'd0, 44'hA4B_3C2D_1E0F));
    apply(i_byte(8'h5A), e_write(0));
    apply(i_nop(), e(2'd0, -1, 1'b0, 1'b0, 1'b1));

    // Reset in the middle of a word: outputs clear at once, nothing written
    tag = "reset_mid";
    apply(i_ls(10'd0), e_shift());
    apply(i_byte(8'h01), e_shift());
    apply(i_byte(8'h02), e_shift());
    apply(i_byte(8'h03), e_shift());
    drive(i_byte(8'h04));
    sys_rst_n = 1'b0;
    #1;
    chk_reset();
    drive(i_nop());
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    apply(i_byte(8'h05), e_idle());
    apply(i_byte(8'h06), e_idle());
    apply(i_nop(), e_idle());

    tag = "end";
    chk("pending_writes", 64'(wr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
